// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC pair owner for the 2-wide frontend: arbitrates ext/exe/dec redirects and gates fetch during refill.
// Optional per-source accepted-redirect counters are enabled by defining REDIRECT_STATS_EN.
module fetch_redirect_ctrl #(
   parameter int                    ADDR_WIDTH    = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
   parameter int                    REFILL_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ext_stall,
   input  logic                  ext_flush,
   input  logic [ADDR_WIDTH-1:0] ext_flush_pc,
   input  logic [1:0]            exe_redirect,
   input  logic [ADDR_WIDTH-1:0] exe_target0,
   input  logic [ADDR_WIDTH-1:0] exe_target1,
   input  logic                  dec_redirect,
   input  logic [ADDR_WIDTH-1:0] dec_target,
   output logic [ADDR_WIDTH-1:0] pc0,
   output logic [ADDR_WIDTH-1:0] pc1,
   output logic                  pc_valid,
   output logic                  flush_if,
   output logic                  flush_id
`ifdef REDIRECT_STATS_EN
   ,
   output logic [31:0]           stat_ext,
   output logic [31:0]           stat_exe,
   output logic [31:0]           stat_dec
`endif
);

   // state     | meaning
   // ST_RUN    | both fetch slots valid, PC advances by 8 on every un-stalled cycle
   // ST_REFILL | fetch slots invalid, PC held, cnt counts down un-stalled cycles
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_REFILL = 1'b1
   } state_t;

   localparam logic [3:0]            CNT_INIT   = 4'(REFILL_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(8);
   localparam logic [ADDR_WIDTH-1:0] SLOT_OFS   = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   pc0_q, pc0_d;
   logic                    suppress_q, suppress_d;

   logic                    hard_redirect;
   logic                    redirect;
   logic [ADDR_WIDTH-1:0]   redirect_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= (CNT_INIT == 4'd0) ? ST_RUN : ST_REFILL;
         cnt_q      <= CNT_INIT;
         pc0_q      <= RESET_PC;
         suppress_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc0_q      <= pc0_d;
         suppress_q <= suppress_d;
      end
   end

   always_comb begin
      hard_redirect = 1'b0;
      redirect      = 1'b0;
      redirect_pc   = dec_target;
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc0_d         = pc0_q;

      // Reset drops every request presented in the same cycle.
      if (!reset) begin
         if (ext_flush) begin
            hard_redirect = 1'b1;
            redirect_pc   = ext_flush_pc;
         end else if (exe_redirect[0]) begin
            hard_redirect = 1'b1;
            redirect_pc   = exe_target0;
         end else if (exe_redirect[1]) begin
            hard_redirect = 1'b1;
            redirect_pc   = exe_target1;
         end
         redirect = hard_redirect || (dec_redirect && !suppress_q);
      end

      // Decode feedback right after an ext/exe redirect refers to squashed code.
      suppress_d = hard_redirect;

      if (redirect) begin
         pc0_d   = redirect_pc & ALIGN_MASK;
         cnt_d   = CNT_INIT;
         state_d = (CNT_INIT == 4'd0) ? ST_RUN : ST_REFILL;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (!ext_stall) begin
                  pc0_d = pc0_q + PC_STEP;
               end
            end
            ST_REFILL: begin
               if (!ext_stall) begin
                  if (cnt_q <= 4'd1) begin
                     state_d = ST_RUN;
                     cnt_d   = 4'd0;
                  end else begin
                     cnt_d = cnt_q - 4'd1;
                  end
               end
            end
         endcase
      end

      flush_if = redirect;
      flush_id = hard_redirect;
   end

   assign pc0      = pc0_q;
   assign pc1      = pc0_q + SLOT_OFS;
   assign pc_valid = (state_q == ST_RUN);

`ifdef REDIRECT_STATS_EN
   logic [31:0] cnt_ext_q;
   logic [31:0] cnt_exe_q;
   logic [31:0] cnt_dec_q;

   // ext_flush is top priority, so a hard redirect without it came from execute.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_ext_q <= '0;
         cnt_exe_q <= '0;
         cnt_dec_q <= '0;
      end else begin
         if (hard_redirect && ext_flush && (cnt_ext_q != 32'hFFFF_FFFF)) begin
            cnt_ext_q <= cnt_ext_q + 32'd1;
         end
         if (hard_redirect && !ext_flush && (cnt_exe_q != 32'hFFFF_FFFF)) begin
            cnt_exe_q <= cnt_exe_q + 32'd1;
         end
         if (redirect && !hard_redirect && (cnt_dec_q != 32'hFFFF_FFFF)) begin
            cnt_dec_q <= cnt_dec_q + 32'd1;
         end
      end
   end

   assign stat_ext = cnt_ext_q;
   assign stat_exe = cnt_exe_q;
   assign stat_dec = cnt_dec_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: two instances (refill 1 and 2) against a per-cycle reference model.
module tb_fetch_redirect_ctrl;

   logic        clk;
   logic        reset;
   logic        ext_stall;
   logic        ext_flush;
   logic [31:0] ext_flush_pc;
   logic [1:0]  exe_redirect;
   logic [31:0] exe_target0;
   logic [31:0] exe_target1;
   logic        dec_redirect;
   logic [31:0] dec_target;

   logic [31:0] a_pc0, a_pc1, b_pc0, b_pc1;
   logic        a_pc_valid, a_flush_if, a_flush_id;
   logic        b_pc_valid, b_flush_if, b_flush_id;
`ifdef REDIRECT_STATS_EN
   logic [31:0] a_stat_ext, a_stat_exe, a_stat_dec;
   logic [31:0] b_stat_ext, b_stat_exe, b_stat_dec;
`endif

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // Reference model: PC and number of un-stalled cycles left before fetch is valid.
   logic [31:0] m_pc [2];
   int          m_left [2];
   int          rc [2];
   bit          m_sup;
   logic [31:0] m_ext, m_exe, m_dec;

   fetch_redirect_ctrl #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .REFILL_CYCLES(1)) dut_a (
      .clk(clk), .reset(reset), .ext_stall(ext_stall), .ext_flush(ext_flush),
      .ext_flush_pc(ext_flush_pc), .exe_redirect(exe_redirect),
      .exe_target0(exe_target0), .exe_target1(exe_target1),
      .dec_redirect(dec_redirect), .dec_target(dec_target),
      .pc0(a_pc0), .pc1(a_pc1), .pc_valid(a_pc_valid),
      .flush_if(a_flush_if), .flush_id(a_flush_id)
`ifdef REDIRECT_STATS_EN
      , .stat_ext(a_stat_ext), .stat_exe(a_stat_exe), .stat_dec(a_stat_dec)
`endif
   );

   fetch_redirect_ctrl #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .REFILL_CYCLES(2)) dut_b (
      .clk(clk), .reset(reset), .ext_stall(ext_stall), .ext_flush(ext_flush),
      .ext_flush_pc(ext_flush_pc), .exe_redirect(exe_redirect),
      .exe_target0(exe_target0), .exe_target1(exe_target1),
      .dec_redirect(dec_redirect), .dec_target(dec_target),
      .pc0(b_pc0), .pc1(b_pc1), .pc_valid(b_pc_valid),
      .flush_if(b_flush_if), .flush_id(b_flush_id)
`ifdef REDIRECT_STATS_EN
      , .stat_ext(b_stat_ext), .stat_exe(b_stat_exe), .stat_dec(b_stat_dec)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      reset        = 1'b0;
      ext_stall    = 1'b0;
      ext_flush    = 1'b0;
      ext_flush_pc = 32'h0;
      exe_redirect = 2'b00;
      exe_target0  = 32'h0;
      exe_target1  = 32'h0;
      dec_redirect = 1'b0;
      dec_target   = 32'h0;
   endtask

   // Compare all outputs mid-cycle, then advance DUTs and model across one posedge.
   task automatic tick();
      logic        hard, dec_ok, take;
      logic [31:0] tgt;
      @(negedge clk);
      hard   = !reset && (ext_flush || (exe_redirect != 2'b00));
      dec_ok = !reset && !hard && dec_redirect && !m_sup;
      take   = hard || dec_ok;
      if (ext_flush)            tgt = ext_flush_pc;
      else if (exe_redirect[0]) tgt = exe_target0;
      else if (exe_redirect[1]) tgt = exe_target1;
      else                      tgt = dec_target;
      if (chk_en) begin
         check("a_pc0",      a_pc0,      m_pc[0]);
         check("a_pc1",      a_pc1,      m_pc[0] + 32'd4);
         check("a_pc_valid", {31'd0, a_pc_valid}, {31'd0, (m_left[0] == 0)});
         check("a_flush_if", {31'd0, a_flush_if}, {31'd0, take});
         check("a_flush_id", {31'd0, a_flush_id}, {31'd0, hard});
         check("b_pc0",      b_pc0,      m_pc[1]);
         check("b_pc1",      b_pc1,      m_pc[1] + 32'd4);
         check("b_pc_valid", {31'd0, b_pc_valid}, {31'd0, (m_left[1] == 0)});
         check("b_flush_if", {31'd0, b_flush_if}, {31'd0, take});
         check("b_flush_id", {31'd0, b_flush_id}, {31'd0, hard});
`ifdef REDIRECT_STATS_EN
         check("a_stat_ext", a_stat_ext, m_ext);
         check("a_stat_exe", a_stat_exe, m_exe);
         check("a_stat_dec", a_stat_dec, m_dec);
         check("b_stat_ext", b_stat_ext, m_ext);
         check("b_stat_exe", b_stat_exe, m_exe);
         check("b_stat_dec", b_stat_dec, m_dec);
`endif
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_pc[i]   = 32'h0;
            m_left[i] = rc[i];
         end else if (take) begin
            m_pc[i]   = {tgt[31:2], 2'b00};
            m_left[i] = rc[i];
         end else if (m_left[i] == 0) begin
            if (!ext_stall) m_pc[i] = m_pc[i] + 32'd8;
         end else if (!ext_stall) begin
            m_left[i] = m_left[i] - 1;
         end
      end
      m_sup = hard;
      if (reset) begin
         m_ext = 32'h0;
         m_exe = 32'h0;
         m_dec = 32'h0;
      end else begin
         if (hard && ext_flush && m_ext != 32'hFFFF_FFFF)  m_ext = m_ext + 32'd1;
         if (hard && !ext_flush && m_exe != 32'hFFFF_FFFF) m_exe = m_exe + 32'd1;
         if (dec_ok && m_dec != 32'hFFFF_FFFF)             m_dec = m_dec + 32'd1;
      end
      #1;
   endtask

   initial begin
      rc[0] = 1;
      rc[1] = 2;
      m_pc[0] = 32'h0; m_pc[1] = 32'h0;
      m_left[0] = 1;   m_left[1] = 2;
      m_sup = 1'b0;
      m_ext = 32'h0; m_exe = 32'h0; m_dec = 32'h0;

      set_idle();
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      set_idle();

      // Reset release and first fetch groups
      check("t1_c1_valid", {31'd0, a_pc_valid}, 32'd0);
      check("t1_c1_pc0", a_pc0, 32'h0);
      tick();
      check("t1_c2_valid", {31'd0, a_pc_valid}, 32'd1);
      check("t1_c2_pc0", a_pc0, 32'h0);
      check("t1_c2_pc1", a_pc1, 32'h4);
      tick();
      check("t1_c3_pc0", a_pc0, 32'h8);
      check("t1_c3_pc1", a_pc1, 32'hC);
      check("t1_c3_b_valid", {31'd0, b_pc_valid}, 32'd1);

      // Both exe ports plus decode in one cycle
      exe_redirect = 2'b11; exe_target0 = 32'h100; exe_target1 = 32'h200;
      dec_redirect = 1'b1;  dec_target  = 32'h500;
      #1;
      check("t2_flush_if", {31'd0, a_flush_if}, 32'd1);
      check("t2_flush_id", {31'd0, a_flush_id}, 32'd1);
      tick();
      set_idle();
      check("t2_a_pc0", a_pc0, 32'h100);
      check("t2_b_pc0", b_pc0, 32'h100);
`ifdef REDIRECT_STATS_EN
      check("t2_stat_exe", a_stat_exe, 32'd1);
      check("t2_stat_dec", a_stat_dec, 32'd0);
`endif

      // Younger exe port, then a suppressed decode redirect
      exe_redirect = 2'b10; exe_target1 = 32'h280;
      tick();
      set_idle();
      dec_redirect = 1'b1; dec_target = 32'h600;
      #1;
      check("t3_sup_flush_if", {31'd0, a_flush_if}, 32'd0);
      tick();
      set_idle();
      check("t3_a_pc0_hold", a_pc0, 32'h280);
      check("t3_b_pc0_hold", b_pc0, 32'h280);
      tick();
      dec_redirect = 1'b1; dec_target = 32'h40;
      #1;
      check("t3_dec_flush_if", {31'd0, a_flush_if}, 32'd1);
      check("t3_dec_flush_id", {31'd0, a_flush_id}, 32'd0);
      tick();
      set_idle();
      check("t3_dec_pc0", a_pc0, 32'h40);
`ifdef REDIRECT_STATS_EN
      check("t3_stat_dec", a_stat_dec, 32'd1);
`endif

      // Redirect under a 3-cycle stall, refill of 2 on dut_b
      exe_redirect = 2'b01; exe_target0 = 32'h300; ext_stall = 1'b1;
      tick();
      set_idle();
      ext_stall = 1'b1;
      check("t4_pc0_now", b_pc0, 32'h300);
      check("t4_valid_r1", {31'd0, b_pc_valid}, 32'd0);
      tick();
      check("t4_valid_r2", {31'd0, b_pc_valid}, 32'd0);
      tick();
      ext_stall = 1'b0;
      check("t4_valid_r3", {31'd0, b_pc_valid}, 32'd0);
      tick();
      check("t4_valid_r4", {31'd0, b_pc_valid}, 32'd0);
      tick();
      check("t4_valid_r5", {31'd0, b_pc_valid}, 32'd1);
      check("t4_pc0_r5", b_pc0, 32'h300);

      // ext_flush beats exe port 0; low bits of target cleared
      ext_flush = 1'b1; ext_flush_pc = 32'h1003;
      exe_redirect = 2'b01; exe_target0 = 32'h2000;
      #1;
      check("t5_flush_if", {31'd0, b_flush_if}, 32'd1);
      check("t5_flush_id", {31'd0, b_flush_id}, 32'd1);
      tick();
      set_idle();
      check("t5_pc0", a_pc0, 32'h1000);
      check("t5_pc1", a_pc1, 32'h1004);
`ifdef REDIRECT_STATS_EN
      check("t5_stat_ext", b_stat_ext, 32'd1);
`endif

      // Wrap at the top of the address space
      ext_flush = 1'b1; ext_flush_pc = 32'hFFFF_FFF8;
      tick();
      set_idle();
      tick();
      tick();
      check("t6_a_wrap_pc0", a_pc0, 32'h0);
      check("t6_a_wrap_pc1", a_pc1, 32'h4);
      check("t6_b_top_pc1", b_pc1, 32'hFFFF_FFFC);
      tick();
      check("t6_b_wrap_pc0", b_pc0, 32'h0);
      check("t6_b_wrap_pc1", b_pc1, 32'h4);

      // Reset mid-refill with every request pending
      ext_flush = 1'b1; ext_flush_pc = 32'h700;
      tick();
      reset = 1'b1; ext_flush = 1'b1; ext_flush_pc = 32'h900;
      exe_redirect = 2'b11; exe_target0 = 32'hA00; exe_target1 = 32'hB00;
      dec_redirect = 1'b1; dec_target = 32'hC00;
      #1;
      check("t6_rst_flush_if", {31'd0, a_flush_if}, 32'd0);
      check("t6_rst_flush_id", {31'd0, a_flush_id}, 32'd0);
      tick();
      set_idle();
      check("t6_rst_a_pc0", a_pc0, 32'h0);
      check("t6_rst_b_pc0", b_pc0, 32'h0);
      check("t6_rst_valid", {31'd0, a_pc_valid}, 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         reset        = ($urandom_range(63) == 0);
         ext_stall    = ($urandom_range(2) == 0);
         ext_flush    = ($urandom_range(15) == 0);
         ext_flush_pc = $urandom();
         exe_redirect = {($urandom_range(7) == 0), ($urandom_range(7) == 0)};
         exe_target0  = $urandom();
         exe_target1  = $urandom();
         dec_redirect = ($urandom_range(3) == 0);
         dec_target   = $urandom();
         tick();
      end
      set_idle();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
